onehot_to_bin: RTL and testbench

//   Registered one-hot to binary encoder; inverse of bin_to_onehot. Accepts a
//   one-hot word over a valid/ready handshake and returns its bit index as a

---
 rtl/onehot_to_bin.sv | 75 +++++++
 tb/tb_onehot_to_bin.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/onehot_to_bin.sv
// Registered one-hot to binary encoder behind a single-entry valid/ready slot.
// Malformed words (zero-hot or multi-hot) are flagged and counted for debug.
module onehot_to_bin #(
   parameter int ONEHOT_WIDTH = 16,
   parameter int BINARY_WIDTH = 4,
   parameter int ERRCNT_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ONEHOT_WIDTH-1:0] onehot,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BINARY_WIDTH-1:0] binary,
   output logic                    out_err,
   output logic [ERRCNT_WIDTH-1:0] err_count,
   input  logic                    err_clear
);

   // Reject parameter combinations the encoder cannot represent
   if (ONEHOT_WIDTH < 2) begin : g_bad_onehot_width
      $error("onehot_to_bin: ONEHOT_WIDTH must be >= 2");
   end
   if (BINARY_WIDTH != $clog2(ONEHOT_WIDTH)) begin : g_bad_binary_width
      $error("onehot_to_bin: BINARY_WIDTH must equal $clog2(ONEHOT_WIDTH)");
   end

   logic                    accept;
   logic                    malformed;
   logic [BINARY_WIDTH-1:0] enc;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Clearing the lowest set bit leaves something only when two or more bits are set
   assign malformed = (onehot == '0) ||
                      ((onehot & (onehot - ONEHOT_WIDTH'(1))) != '0);

   // Scan downward so the lowest set bit wins on multi-hot words
   always_comb begin
      enc = '0;
      for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
         if (onehot[i]) begin
            enc = BINARY_WIDTH'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         binary    <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         binary    <= enc;
         out_err   <= malformed;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Clear outranks a same-cycle malformed accept; the count sticks at all-ones
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_count <= '0;
      end else if (err_clear) begin
         err_count <= '0;
      end else if (accept && malformed && (err_count != '1)) begin
         err_count <= err_count + ERRCNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_onehot_to_bin.sv
// Directed and randomized checks of onehot_to_bin against a behavioural model
// of the handshake, the lowest-set-bit encoding and the saturating error count.
module tb_onehot_to_bin;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] onehot;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  binary;
   logic        out_err;
   logic [7:0]  err_count;
   logic        err_clear;

   int checks = 0;
   int errors = 0;

   logic       m_valid;
   int         m_bin;
   logic       m_err;
   int         m_cnt;

   onehot_to_bin #(
      .ONEHOT_WIDTH(16),
      .BINARY_WIDTH(4),
      .ERRCNT_WIDTH(8)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .onehot   (onehot),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .binary   (binary),
      .out_err  (out_err),
      .err_count(err_count),
      .err_clear(err_clear)
   );

   always #5 clk = ~clk;

   // Isolate the lowest set bit arithmetically, then take its log2
   function automatic int ref_index(input logic [15:0] w);
      int v;
      int low;
      v   = int'(w);
      low = v & (-v);
      return $clog2(low);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_bin   = 0;
      m_err   = 1'b0;
      m_cnt   = 0;
   endtask

   // One clock cycle with the currently driven inputs, then compare all outputs
   task automatic applyStimulus(input string tag);
      logic acc;
      logic bad;
      #1;
      checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || out_ready));
      acc = in_valid && (!m_valid || out_ready);
      bad = ($countones(onehot) != 1);
      if (acc) begin
         m_valid = 1'b1;
         m_bin   = ref_index(onehot);
         m_err   = bad;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      if (err_clear) m_cnt = 0;
      else if (acc && bad && m_cnt < 255) m_cnt++;
      @(posedge clk);
      #1;
      checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      checkOutput({tag, ".binary"}, 32'(binary), 32'(m_bin));
      checkOutput({tag, ".out_err"}, 32'(out_err), 32'(m_err));
      checkOutput({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
   endtask

   task automatic drive(input logic v, input logic [15:0] w, input logic rdy);
      in_valid  = v;
      onehot    = w;
      out_ready = rdy;
   endtask

   initial begin
      logic [15:0] w;
      reset     = 1'b1;
      err_clear = 1'b0;
      drive(1'b0, 16'h0000, 1'b0);
      model_reset();

      $display("[TB] reset state");
      repeat (2) @(posedge clk);
      #3;
      checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst.binary", 32'(binary), 32'd0);
      checkOutput("rst.out_err", 32'(out_err), 32'd0);
      checkOutput("rst.err_count", 32'(err_count), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst.in_ready", 32'(in_ready), 32'd1);

      $display("[TB] back-to-back legal words");
      drive(1'b1, 16'h0001, 1'b1); applyStimulus("s0");
      checkOutput("s0.bin0", 32'(binary), 32'd0);
      drive(1'b1, 16'h0010, 1'b1); applyStimulus("s1");
      checkOutput("s1.bin4", 32'(binary), 32'd4);
      drive(1'b1, 16'h8000, 1'b1); applyStimulus("s2");
      checkOutput("s2.bin15", 32'(binary), 32'd15);

      $display("[TB] malformed words");
      drive(1'b1, 16'h0000, 1'b1); applyStimulus("zh");
      checkOutput("zh.cnt1", 32'(err_count), 32'd1);
      drive(1'b1, 16'h0060, 1'b1); applyStimulus("mh");
      checkOutput("mh.bin5", 32'(binary), 32'd5);
      checkOutput("mh.cnt2", 32'(err_count), 32'd2);

      $display("[TB] backpressure");
      drive(1'b1, 16'h0100, 1'b1); applyStimulus("bp.acc");
      drive(1'b1, 16'h0004, 1'b0);
      repeat (3) applyStimulus("bp.hold");
      checkOutput("bp.bin8", 32'(binary), 32'd8);
      drive(1'b1, 16'h0004, 1'b1); applyStimulus("bp.rel");
      checkOutput("bp.bin2", 32'(binary), 32'd2);
      drive(1'b0, 16'h0000, 1'b1); applyStimulus("bp.drain");

      $display("[TB] error counter saturation");
      for (int i = 0; i < 300; i++) begin
         w = 16'($urandom);
         if ($countones(w) == 1) w = 16'h0000;
         drive(1'b1, w, 1'b1);
         applyStimulus("sat");
      end
      checkOutput("sat.255", 32'(err_count), 32'd255);
      err_clear = 1'b1;
      drive(1'b1, 16'h0003, 1'b1); applyStimulus("clr");
      checkOutput("clr.zero", 32'(err_count), 32'd0);
      err_clear = 1'b0;

      $display("[TB] reset mid-transfer");
      drive(1'b1, 16'h0400, 1'b0); applyStimulus("mr.fill");
      drive(1'b0, 16'h0000, 1'b0);
      reset = 1'b1;
      #1;
      checkOutput("mr.out_valid", 32'(out_valid), 32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      drive(1'b0, 16'h0000, 1'b1);
      repeat (3) applyStimulus("mr.stale");

      $display("[TB] random legal words");
      for (int i = 0; i < 32; i++) begin
         w = 16'h0001 << $urandom_range(0, 15);
         drive(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 1)));
         applyStimulus("rnd");
         checkOutput("rnd.noerr", 32'(out_err), 32'd0);
      end
      drive(1'b0, 16'h0000, 1'b1);
      repeat (2) applyStimulus("end.drain");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
